// File: rtl/button_conditioner_pkg.sv
// Shared constants, width helper and counter-action encoding for button_conditioner.
package button_conditioner_pkg;

    localparam int unsigned DEFAULT_SAMPLE_CNT_MAX = 62500;
    localparam int unsigned DEFAULT_PULSE_CNT_MAX  = 200;

    // Width needed to hold values 0..max_count-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    localparam int unsigned DEFAULT_PRESCALE_W = cnt_width(DEFAULT_SAMPLE_CNT_MAX);
    localparam int unsigned DEFAULT_CHANNEL_W  = cnt_width(DEFAULT_PULSE_CNT_MAX + 1);

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_CLEAR,
        CNT_INC
    } cnt_action_e;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-FF synchronizer, saturating debounce counter, level and edge pulses.
// Optional falling-edge output when BUTTON_CONDITIONER_RELEASE_EN is defined.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned PULSE_CNT_MAX = DEFAULT_PULSE_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic sample_tick,
    output logic debounced,
`ifdef BUTTON_CONDITIONER_RELEASE_EN
    output logic release_pulse,
`endif
    output logic press_pulse
);

    localparam int unsigned CNT_W = cnt_width(PULSE_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(PULSE_CNT_MAX);

    logic             sync_meta;
    logic             sync_in;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             debounced_q;
    cnt_action_e      action;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_in   <= 1'b0;
        end else begin
            sync_meta <= async_in;
            sync_in   <= sync_meta;
        end
    end

    always_comb begin
        action     = CNT_HOLD;
        count_next = count;
        if (!sync_in) begin
            action = CNT_CLEAR;
        end else if (sample_tick && (count != COUNT_FULL)) begin
            action = CNT_INC;
        end
        unique case (action)
            CNT_CLEAR: count_next = '0;
            CNT_INC:   count_next = count + CNT_W'(1);
            default:   count_next = count;
        endcase
    end

    // Level is gated by the current synced sample so a low input drops it one
    // cycle after synchronisation rather than waiting for the counter to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            debounced   <= 1'b0;
            debounced_q <= 1'b0;
        end else begin
            count       <= count_next;
            debounced   <= sync_in && (count == COUNT_FULL);
            debounced_q <= debounced;
        end
    end

    assign press_pulse = debounced & ~debounced_q;

`ifdef BUTTON_CONDITIONER_RELEASE_EN
    assign release_pulse = ~debounced & debounced_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button/switch conditioner sharing one sample-tick prescaler.
// Define BUTTON_CONDITIONER_RELEASE_EN to add the release_pulse output.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
    parameter int unsigned PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press_pulse,
`ifdef BUTTON_CONDITIONER_RELEASE_EN
    output logic [WIDTH-1:0] release_pulse,
`endif
    output logic             sample_tick
);

    localparam int unsigned PRESCALE_W = cnt_width(SAMPLE_CNT_MAX);
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(SAMPLE_CNT_MAX - 1);

    logic [PRESCALE_W-1:0] prescale;
    logic                  prescale_wrap;

    assign prescale_wrap = (prescale == PRESCALE_LAST);

    // Free-running divider; the tick lands the cycle after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale    <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= prescale_wrap;
            prescale    <= prescale_wrap ? '0 : prescale + PRESCALE_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
        debounce_channel #(
            .PULSE_CNT_MAX(PULSE_CNT_MAX)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .async_in     (async_in[i]),
            .sample_tick  (sample_tick),
            .debounced    (debounced[i]),
`ifdef BUTTON_CONDITIONER_RELEASE_EN
            .release_pulse(release_pulse[i]),
`endif
            .press_pulse  (press_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] async_in;
    logic [1:0] debounced;
    logic [1:0] press_pulse;
    logic       sample_tick;
`ifdef BUTTON_CONDITIONER_RELEASE_EN
    logic [1:0] release_pulse;
`endif

    always #5 clk = ~clk;

    button_conditioner #(
        .WIDTH         (2),
        .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .async_in     (async_in),
        .debounced    (debounced),
        .press_pulse  (press_pulse),
`ifdef BUTTON_CONDITIONER_RELEASE_EN
        .release_pulse(release_pulse),
`endif
        .sample_tick  (sample_tick)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] deb;
        logic [1:0] pls;
        logic [1:0] rel;
        logic       tick;
    } vec_t;

    vec_t vecs[20];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] deb, input logic [1:0] pls,
                              input logic [1:0] rel, input logic tick);
        check({tag, "_deb"}, 32'(debounced), 32'(deb));
        check({tag, "_pls"}, 32'(press_pulse), 32'(pls));
        check({tag, "_tick"}, 32'(sample_tick), 32'(tick));
`ifdef BUTTON_CONDITIONER_RELEASE_EN
        check({tag, "_rel"}, 32'(release_pulse), 32'(rel));
`else
        if (rel != 2'b00) $display("note: release expectation skipped for %s", tag);
`endif
    endtask

    // Both inputs held high since reset release: qualification completes on edge 14.
    task automatic run_held(input string tag);
        for (int j = 1; j <= 16; j++) begin
            step();
            check_outs($sformatf("%s_c%0d", tag, j),
                       (j >= 14) ? 2'b11 : 2'b00,
                       (j == 14) ? 2'b11 : 2'b00,
                       2'b00,
                       (j % 4) == 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_ticks;
        int last_tick;
        int lat;
        bit found;

        vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[2]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[3]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
        vecs[4]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[6]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[7]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
        vecs[8]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[9]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[11] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
        vecs[12] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[13] = '{2'b01, 2'b01, 2'b01, 2'b00, 1'b0};
        vecs[14] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
        vecs[15] = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
        vecs[16] = '{2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
        vecs[17] = '{2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
        vecs[18] = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
        vecs[19] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

        // Reset held with both inputs active.
        rst_n    = 1'b0;
        async_in = 2'b11;
        #2;
        for (int j = 1; j <= 3; j++) begin
            step();
            check_outs($sformatf("rst_c%0d", j), 2'b00, 2'b00, 2'b00, 1'b0);
        end

        // Release with both pressed: simultaneous fresh qualification.
        rst_n = 1'b1;
        run_held("simul");

        // Asynchronous reset mid-press clears outputs without a clock edge.
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 2'b00, 2'b00, 2'b00, 1'b0);
        step();
        rst_n = 1'b1;
        run_held("requal");

        // Clean press, hold and release on channel 0.
        rst_n    = 1'b0;
        async_in = 2'b00;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            async_in = vecs[i].a;
            step();
            check_outs($sformatf("row%0d", i + 1), vecs[i].deb, vecs[i].pls, vecs[i].rel, vecs[i].tick);
        end

        // Bounce: one low cycle every five keeps the counter from saturating.
        rst_n    = 1'b0;
        async_in = 2'b00;
        step();
        rst_n = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            async_in = {1'b0, (j % 5) != 0};
            step();
            check($sformatf("bounce_c%0d_deb", j), 32'(debounced), 32'd0);
            check($sformatf("bounce_c%0d_pls", j), 32'(press_pulse), 32'd0);
        end
        async_in = 2'b01;
        found    = 1'b0;
        lat      = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (!found && debounced[0]) begin
                found = 1'b1;
                lat   = k;
                check("stable_pls", 32'(press_pulse), 32'd1);
            end
        end
        check("stable_found", 32'(found), 32'd1);
        check("stable_latency", 32'(lat), 32'd14);

        // Free-running scheduler.
        n_ticks   = 0;
        last_tick = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (sample_tick) begin
                n_ticks++;
                if (last_tick >= 0) check($sformatf("tick_gap_c%0d", c), 32'(c - last_tick), 32'd4);
                last_tick = c;
            end
        end
        check("tick_count", 32'(n_ticks), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
